// File: rtl/regfile_pkg.sv
// Shared register-file constants and writeback requester indices.
package regfile_pkg;

  localparam int          REG_AW   = 5;
  localparam int          REG_DW   = 32;
  localparam logic [4:0]  REG_ZERO = 5'd0;

  localparam int WB_ALU    = 0;
  localparam int WB_LOAD   = 1;
  localparam int WB_MULDIV = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter with an urgent (forced-priority) override.
// Urgent requests win lowest-index-first; otherwise scan from ptr upward with wrap.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic [N-1:0]  urgent,
  output logic [N-1:0]  grant
);

  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && urgent[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    // Two passes emulate a rotated priority: indices at/after ptr, then the wrap.
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i < int'(ptr))) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NREQ writeback requesters.
// Optional decode bypass outputs are enabled with REGFILE_WB_FWD_EN.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int MAX_WAIT = 4,
  parameter int AW       = REG_AW,
  parameter int DW       = REG_DW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 wen,
  output logic [AW-1:0]        waddr,
  output logic [DW-1:0]        wdata,
`ifdef REGFILE_WB_FWD_EN
  input  logic [AW-1:0]        fwd_raddr1,
  input  logic [AW-1:0]        fwd_raddr2,
  output logic                 fwd_hit1,
  output logic                 fwd_hit2,
  output logic [DW-1:0]        fwd_data,
`endif
  output logic [(1<<AW)-1:0]   pend_mask
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW   = 4;
  localparam int NREG = 1 << AW;

  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   ptr_nxt;
  logic [CW-1:0]   wait_cnt [NREQ];
  logic [NREQ-1:0] urgent;
  logic [NREQ-1:0] req_eff;
  logic [NREQ-1:0] grant;
  logic            vld_p0;
  logic [AW-1:0]   addr_p0;
  logic [DW-1:0]   data_p0;
  logic            wr_p0;
  logic [NREG-1:0] onehot_p0;

  logic            wen_p1;
  logic [AW-1:0]   waddr_p1;
  logic [DW-1:0]   wdata_p1;
  logic [NREG-1:0] pend_p1;

  // Stage 0: arbitration and selection of the winning requester
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      urgent[i] = req_valid[i] && (wait_cnt[i] == CW'(MAX_WAIT));
    end
  end

  assign req_eff = stall ? '0 : req_valid;

  rr_arbiter #(
    .N  (NREQ),
    .PW (PW)
  ) u_rr_arbiter (
    .req    (req_eff),
    .ptr    (rr_ptr),
    .urgent (urgent),
    .grant  (grant)
  );

  assign req_ready = grant;
  assign vld_p0    = |grant;

  always_comb begin
    addr_p0 = '0;
    data_p0 = '0;
    ptr_nxt = rr_ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        addr_p0 = req_addr[i*AW +: AW];
        data_p0 = req_data[i*DW +: DW];
        ptr_nxt = (i == NREQ - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  // A write to r0 is consumed but never reaches the register file.
  assign wr_p0     = vld_p0 && (addr_p0 != AW'(REG_ZERO));
  assign onehot_p0 = NREG'(1) << addr_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      for (int i = 0; i < NREQ; i++) begin
        wait_cnt[i] <= '0;
      end
    end else begin
      if (vld_p0) begin
        rr_ptr <= ptr_nxt;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || grant[i]) begin
          wait_cnt[i] <= '0;
        end else if (wait_cnt[i] != CW'(MAX_WAIT)) begin
          wait_cnt[i] <= wait_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Stage 1: registered write port and pending mask
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_p1   <= 1'b0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
      pend_p1  <= '0;
    end else if (vld_p0) begin
      wen_p1   <= wr_p0;
      waddr_p1 <= addr_p0;
      wdata_p1 <= data_p0;
      pend_p1  <= wr_p0 ? onehot_p0 : '0;
    end else begin
      wen_p1  <= 1'b0;
      pend_p1 <= '0;
    end
  end

  assign wen       = wen_p1;
  assign waddr     = waddr_p1;
  assign wdata     = wdata_p1;
  assign pend_mask = pend_p1;

`ifdef REGFILE_WB_FWD_EN
  assign fwd_hit1 = wen_p1 && (waddr_p1 == fwd_raddr1) && (waddr_p1 != AW'(REG_ZERO));
  assign fwd_hit2 = wen_p1 && (waddr_p1 == fwd_raddr2) && (waddr_p1 != AW'(REG_ZERO));
  assign fwd_data = wdata_p1;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Table-driven bench for regfile_wb_arbiter with a write scoreboard (MAX_WAIT=2).
module tb_regfile_wb_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                stall;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*DW-1:0]  req_data;
  logic [NREQ-1:0]     req_ready;
  logic                wen;
  logic [AW-1:0]       waddr;
  logic [DW-1:0]       wdata;
  logic [31:0]         pend_mask;
`ifdef REGFILE_WB_FWD_EN
  logic [AW-1:0]       fwd_raddr1 = 5'd3;
  logic [AW-1:0]       fwd_raddr2 = 5'd0;
  logic                fwd_hit1;
  logic                fwd_hit2;
  logic [DW-1:0]       fwd_data;
`endif

  regfile_wb_arbiter #(
    .NREQ(NREQ), .MAX_WAIT(2), .AW(AW), .DW(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .wen(wen), .waddr(waddr), .wdata(wdata),
`ifdef REGFILE_WB_FWD_EN
    .fwd_raddr1(fwd_raddr1), .fwd_raddr2(fwd_raddr2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data(fwd_data),
`endif
    .pend_mask(pend_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    string              name;
    logic [2:0]         valid;
    logic               stall;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] data;
    logic [2:0]         ready;
  } vec_t;

  typedef struct {
    string       name;
    logic        wen;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [4:0]  last_addr = '0;
  logic [31:0] last_data = '0;
  logic [31:0] regs [32];

  function automatic vec_t mk(input string nm, input logic [2:0] v, input logic st,
                              input logic [4:0] a2, input logic [4:0] a1, input logic [4:0] a0,
                              input logic [31:0] d2, input logic [31:0] d1, input logic [31:0] d0,
                              input logic [2:0] r);
    vec_t t;
    t.name = nm; t.valid = v; t.stall = st;
    t.addr = {a2, a1, a0}; t.data = {d2, d1, d0}; t.ready = r;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_outputs(input exp_t e);
    chk({e.name, ":wen"}, 64'(wen), 64'(e.wen));
    chk({e.name, ":waddr"}, 64'(waddr), 64'(e.addr));
    chk({e.name, ":wdata"}, 64'(wdata), 64'(e.data));
    chk({e.name, ":pend"}, 64'(pend_mask), e.wen ? 64'(32'd1 << e.addr) : 64'd0);
`ifdef REGFILE_WB_FWD_EN
    chk({e.name, ":fwd_hit1"}, 64'(fwd_hit1), 64'(e.wen && e.addr == 5'd3));
    chk({e.name, ":fwd_hit2"}, 64'(fwd_hit2), 64'd0);
    chk({e.name, ":fwd_data"}, 64'(fwd_data), 64'(e.data));
`endif
  endtask

  task automatic step(input vec_t v);
    exp_t e;
    req_valid = v.valid;
    stall     = v.stall;
    req_addr  = v.addr;
    req_data  = v.data;
    @(negedge clk);
    chk({v.name, ":ready"}, 64'(req_ready), 64'(v.ready));
    e.name = v.name;
    e.wen  = 1'b0;
    e.addr = last_addr;
    e.data = last_data;
    for (int i = 0; i < NREQ; i++) begin
      if (v.ready[i]) begin
        e.addr = v.addr[i*AW +: AW];
        e.data = v.data[i*DW +: DW];
        e.wen  = (e.addr != 5'd0);
      end
    end
    last_addr = e.addr;
    last_data = e.data;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s:scoreboard got empty expected entry", v.name);
    end else begin
      e = sb.pop_front();
      check_outputs(e);
    end
    if (wen) regs[waddr] = wdata;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = '0;
    rst_n = 1'b0; stall = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;

    vecs.push_back(mk("single",     3'b010, 0, 0, 7, 0, 0, 32'hDEADBEEF, 0, 3'b010));
    vecs.push_back(mk("idle",       3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b000));
    vecs.push_back(mk("ptr_to0",    3'b100, 0, 1, 0, 0, 32'h22220001, 0, 0, 3'b100));
    vecs.push_back(mk("rr0",        3'b111, 0, 12, 11, 10, 32'hC2, 32'hC1, 32'hC0, 3'b001));
    vecs.push_back(mk("rr1",        3'b111, 0, 12, 11, 10, 32'hC2, 32'hC1, 32'hC0, 3'b010));
    vecs.push_back(mk("rr2",        3'b111, 0, 12, 11, 10, 32'hC2, 32'hC1, 32'hC0, 3'b100));
    vecs.push_back(mk("rr3",        3'b111, 0, 12, 11, 10, 32'hC2, 32'hC1, 32'hC0, 3'b001));
    vecs.push_back(mk("rr4",        3'b111, 0, 12, 11, 10, 32'hC2, 32'hC1, 32'hC0, 3'b010));
    vecs.push_back(mk("rr5",        3'b111, 0, 12, 11, 10, 32'hC2, 32'hC1, 32'hC0, 3'b100));
    vecs.push_back(mk("drop",       3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b000));
    vecs.push_back(mk("seed_ptr1",  3'b001, 0, 0, 0, 4, 0, 0, 32'h44440004, 3'b001));
    vecs.push_back(mk("stall_a",    3'b011, 1, 0, 21, 20, 0, 32'hB1, 32'hA0, 3'b000));
    vecs.push_back(mk("stall_b",    3'b011, 1, 0, 21, 20, 0, 32'hB1, 32'hA0, 3'b000));
    vecs.push_back(mk("forced0",    3'b011, 0, 0, 21, 20, 0, 32'hB1, 32'hA0, 3'b001));
    vecs.push_back(mk("then1",      3'b010, 0, 0, 21, 20, 0, 32'hB1, 32'hA0, 3'b010));
    vecs.push_back(mk("r0_write",   3'b100, 0, 0, 0, 0, 32'h12345678, 0, 0, 3'b100));
    vecs.push_back(mk("no_reissue", 3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b000));
    vecs.push_back(mk("seed_col",   3'b001, 0, 0, 0, 9, 0, 0, 32'h99, 3'b001));
    vecs.push_back(mk("col_b",      3'b011, 0, 0, 3, 3, 0, 32'hBBBB0003, 32'hAAAA0003, 3'b010));
    vecs.push_back(mk("col_a",      3'b001, 0, 0, 3, 3, 0, 32'hBBBB0003, 32'hAAAA0003, 3'b001));

    repeat (2) @(posedge clk);
    #1;
    chk("reset:wen", 64'(wen), 64'd0);
    chk("reset:waddr", 64'(waddr), 64'd0);
    chk("reset:wdata", 64'(wdata), 64'd0);
    chk("reset:pend", 64'(pend_mask), 64'd0);
    rst_n = 1'b1;

    foreach (vecs[k]) step(vecs[k]);
    chk("collision:reg3", 64'(regs[3]), 64'h0000_0000_AAAA_0003);

    // Reset asserted while a granted write sits in the output stage.
    req_valid = 3'b010; req_addr = {5'd0, 5'd8, 5'd0}; req_data = {32'd0, 32'h88, 32'd0};
    @(negedge clk);
    chk("midrst:ready", 64'(req_ready), 64'b010);
    @(posedge clk);
    #1;
    chk("midrst:wen_before", 64'(wen), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst:wen", 64'(wen), 64'd0);
    chk("midrst:pend", 64'(pend_mask), 64'd0);
    chk("midrst:waddr", 64'(waddr), 64'd0);
    req_valid = 3'b111;
    req_addr  = {5'd17, 5'd16, 5'd15};
    req_data  = {32'h1700, 32'h1600, 32'h1500};
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst:ready", 64'(req_ready), 64'b001);
    @(posedge clk);
    #1;
    chk("postrst:wen", 64'(wen), 64'd1);
    chk("postrst:waddr", 64'(waddr), 64'd15);
    chk("postrst:wdata", 64'(wdata), 64'h1500);
    req_valid = '0;
    @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
